// File: rtl/adder_share_arbiter_if.sv
// Signal bundle shared by the requesters, the arbiter and the single shared adder.
interface adder_share_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_sum;
    logic                          adder_enable;
    logic [DATA_WIDTH-1:0]         adder_a;
    logic [DATA_WIDTH-1:0]         adder_b;
    logic [DATA_WIDTH-1:0]         adder_sum;
    logic                          busy;

    // Environment side: requesters plus the shared adder.
    modport master (
        output req_valid, req_a, req_b, adder_sum,
        input  req_ready, resp_valid, resp_sum, adder_enable, adder_a, adder_b, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, adder_sum,
        output req_ready, resp_valid, resp_sum, adder_enable, adder_a, adder_b, busy
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered saturating Q10.5 adder
// between NUM_REQ requesters. One operation in flight at a time; the sum is
// passed through untouched and returned with a one-hot strobe to its owner.
module adder_share_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int FRAC_BITS     = 5,
    parameter int ADDER_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_share_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (ADDER_LATENCY > 1) ? $clog2(ADDER_LATENCY) : 1;

    // FRAC_BITS only documents the Q format; no arithmetic happens here.
    if (NUM_REQ < 2 || NUM_REQ > 8 || ADDER_LATENCY < 1 ||
        FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_param_check
        $error("adder_share_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      grant_id;
    logic [CNT_W-1:0]      wait_cnt;
    logic [DATA_WIDTH-1:0] adder_a_q;
    logic [DATA_WIDTH-1:0] adder_b_q;
    logic [DATA_WIDTH-1:0] resp_sum_q;
    logic [NUM_REQ-1:0]    resp_valid_q;

    // Round-robin search results
    logic                  hi_found;
    logic [PTR_W-1:0]      hi_idx;
    logic [DATA_WIDTH-1:0] hi_a;
    logic [DATA_WIDTH-1:0] hi_b;
    logic                  lo_found;
    logic [PTR_W-1:0]      lo_idx;
    logic [DATA_WIDTH-1:0] lo_a;
    logic [DATA_WIDTH-1:0] lo_b;
    logic                  any_valid;
    logic [PTR_W-1:0]      winner;
    logic [DATA_WIDTH-1:0] win_a;
    logic [DATA_WIDTH-1:0] win_b;
    logic [PTR_W-1:0]      ptr_next;

    // Pick the first valid requester at or above ptr, else the first below it.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        hi_a     = '0;
        hi_b     = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        lo_a     = '0;
        lo_b     = '0;
        // Descending scan: the last hit in each half is its lowest index.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                if (PTR_W'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = PTR_W'(i);
                    hi_a     = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
                    hi_b     = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = PTR_W'(i);
                    lo_a     = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
                    lo_b     = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        any_valid = hi_found | lo_found;
        winner    = hi_found ? hi_idx : lo_idx;
        win_a     = hi_found ? hi_a   : lo_a;
        win_b     = hi_found ? hi_b   : lo_b;
        ptr_next  = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end

    // State register.
    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the state-derived outputs (req_ready is Mealy in IDLE).
    always_comb begin
        next_state       = state;
        bus.req_ready    = '0;
        bus.adder_enable = 1'b0;
        bus.busy         = (state != IDLE);
        unique case (state)
            IDLE: begin
                // Held at zero while reset is asserted, even with requests pending.
                if (any_valid && rst_n) begin
                    bus.req_ready = NUM_REQ'(1) << winner;
                end
                if (any_valid) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                bus.adder_enable = 1'b1;
                next_state       = WAIT;
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture, pointer update, latency countdown and result return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            grant_id     <= '0;
            wait_cnt     <= '0;
            adder_a_q    <= '0;
            adder_b_q    <= '0;
            resp_sum_q   <= '0;
            resp_valid_q <= '0;
        end else begin
            resp_valid_q <= '0;
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        adder_a_q <= win_a;
                        adder_b_q <= win_b;
                        grant_id  <= winner;
                        ptr       <= ptr_next;
                    end
                end
                ISSUE: begin
                    wait_cnt <= CNT_W'(ADDER_LATENCY - 1);
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        resp_sum_q   <= bus.adder_sum;
                        resp_valid_q <= NUM_REQ'(1) << grant_id;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.adder_a    = adder_a_q;
    assign bus.adder_b    = adder_b_q;
    assign bus.resp_sum   = resp_sum_q;
    assign bus.resp_valid = resp_valid_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench: two arbiter builds (ADDER_LATENCY 1 and 3), each with a
// behavioural saturating adder hanging off its adder port.
module tb_adder_share_arbiter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    adder_share_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(16)) bus0 ();
    adder_share_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(16)) bus3 ();

    adder_share_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .FRAC_BITS(5), .ADDER_LATENCY(1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    adder_share_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .FRAC_BITS(5), .ADDER_LATENCY(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s[16] != s[15]) return s[16] ? 16'h8000 : 16'h7FFF;
        return s[15:0];
    endfunction

    // Shared adder, latency 1.
    logic [15:0] sum0 = '0;
    always @(posedge clk) if (bus0.adder_enable) sum0 <= sat_add(bus0.adder_a, bus0.adder_b);
    assign bus0.adder_sum = sum0;

    // Shared adder, latency 3.
    logic [15:0] s3 [3] = '{16'h0, 16'h0, 16'h0};
    always @(posedge clk) begin
        if (bus3.adder_enable) s3[0] <= sat_add(bus3.adder_a, bus3.adder_b);
        s3[1] <= s3[0];
        s3[2] <= s3[1];
    end
    assign bus3.adder_sum = s3[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input int r, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_sum);
        int lat;
        bus0.req_a[r*16 +: 16] = a;
        bus0.req_b[r*16 +: 16] = b;
        bus0.req_valid = 4'(1 << r);
        #1;
        check({tag, "_ready"}, 32'(bus0.req_ready), 32'(1) << r);
        check({tag, "_idle"}, 32'(bus0.busy), 0);
        step();
        bus0.req_valid = '0;
        #1;
        check({tag, "_en"}, 32'(bus0.adder_enable), 1);
        check({tag, "_a"}, 32'(bus0.adder_a), 32'(a));
        check({tag, "_b"}, 32'(bus0.adder_b), 32'(b));
        check({tag, "_busy"}, 32'(bus0.busy), 1);
        lat = 1;
        while (bus0.resp_valid == '0 && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, lat, 3);
        check({tag, "_rv"}, 32'(bus0.resp_valid), 32'(1) << r);
        check({tag, "_sum"}, 32'(bus0.resp_sum), 32'(exp_sum));
        step();
        check({tag, "_rv_off"}, 32'(bus0.resp_valid), 0);
        check({tag, "_sum_hold"}, 32'(bus0.resp_sum), 32'(exp_sum));
        check({tag, "_busy_off"}, 32'(bus0.busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ord [5];
        logic [15:0] exp_rr [5];
        int ng;
        int nresp;
        int cyc;
        int g;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus0.req_valid = '0;
        bus0.req_a     = '0;
        bus0.req_b     = '0;
        bus3.req_valid = '0;
        bus3.req_a     = '0;
        bus3.req_b     = '0;
        repeat (2) step();

        // Reset state.
        check("rst_ready", 32'(bus0.req_ready), 0);
        check("rst_rv", 32'(bus0.resp_valid), 0);
        check("rst_sum", 32'(bus0.resp_sum), 0);
        check("rst_en", 32'(bus0.adder_enable), 0);
        check("rst_a", 32'(bus0.adder_a), 0);
        check("rst_b", 32'(bus0.adder_b), 0);
        check("rst_busy", 32'(bus0.busy), 0);
        check("rst_busy3", 32'(bus3.busy), 0);

        // All four requesters valid from reset; requester 0 re-requests in its DONE cycle.
        bus0.req_a = {16'h1000, 16'hFFE0, 16'h0100, 16'h0020};
        bus0.req_b = {16'h1000, 16'h0010, 16'h0001, 16'h0040};
        bus0.req_valid = 4'b1111;
        #1;
        check("rst_ready_gated", 32'(bus0.req_ready), 0);
        exp_ord = '{0, 1, 2, 3, 0};
        exp_rr  = '{16'h0060, 16'h0101, 16'hFFF0, 16'h2000, 16'h0007};
        @(negedge clk);
        rst_n = 1'b1;
        ng    = 0;
        nresp = 0;
        cyc   = 0;
        while ((ng < 5 || nresp < 5) && cyc < 60) begin
            #1;
            g = -1;
            if (bus0.req_ready != '0) begin
                if (ng < 5) begin
                    check($sformatf("rr_grant%0d", ng), 32'(bus0.req_ready), 32'(1) << exp_ord[ng]);
                    check($sformatf("rr_acc_cyc%0d", ng), cyc, 4 * ng);
                end
                for (int k = 3; k >= 0; k--) if (bus0.req_ready[k]) g = k;
                ng++;
            end
            if (bus0.resp_valid != '0) begin
                if (nresp < 5) begin
                    check($sformatf("rr_rv%0d", nresp), 32'(bus0.resp_valid), 32'(1) << exp_ord[nresp]);
                    check($sformatf("rr_sum%0d", nresp), 32'(bus0.resp_sum), 32'(exp_rr[nresp]));
                    check($sformatf("rr_resp_cyc%0d", nresp), cyc, 4 * nresp + 3);
                end
                if (nresp == 0) begin
                    bus0.req_a[15:0]  = 16'h0003;
                    bus0.req_b[15:0]  = 16'h0004;
                    bus0.req_valid[0] = 1'b1;
                end
                nresp++;
            end
            step();
            if (g >= 0) bus0.req_valid[g] = 1'b0;
            cyc++;
        end
        check("rr_grants", ng, 5);
        check("rr_resps", nresp, 5);

        // Single operations, latency 1.
        do_op("op0", 0, 16'h0050, 16'h2030, 16'h2080);
        do_op("neg2", 2, 16'hFC40, 16'h0080, 16'hFCC0);
        do_op("satp1", 1, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        do_op("satn3", 3, 16'h8000, 16'hF838, 16'h8000);

        // Latency-3 build: enable one cycle, busy t+1..t+5, result at t+5.
        bus3.req_a[31:16] = 16'h0050;
        bus3.req_b[31:16] = 16'h2030;
        bus3.req_valid    = 4'b0010;
        #1;
        check("l3_ready", 32'(bus3.req_ready), 'h2);
        step();
        bus3.req_valid = '0;
        #1;
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("l3_en_t%0d", k), 32'(bus3.adder_enable), (k == 1) ? 1 : 0);
            check($sformatf("l3_busy_t%0d", k), 32'(bus3.busy), (k <= 5) ? 1 : 0);
            check($sformatf("l3_rv_t%0d", k), 32'(bus3.resp_valid), (k == 5) ? 2 : 0);
            if (k == 5) check("l3_sum", 32'(bus3.resp_sum), 'h2080);
            if (k < 6) step();
        end

        // Reset asserted while an operation sits in WAIT.
        bus0.req_a[63:48] = 16'h0100;
        bus0.req_b[63:48] = 16'h0100;
        bus0.req_valid    = 4'b1000;
        #1;
        check("mid_ready", 32'(bus0.req_ready), 'h8);
        step();
        bus0.req_valid = '0;
        #1;
        check("mid_issue", 32'(bus0.adder_enable), 1);
        step();
        check("mid_wait_busy", 32'(bus0.busy), 1);
        check("mid_wait_en", 32'(bus0.adder_enable), 0);
        bus0.req_a[15:0] = 16'h0001;
        bus0.req_b[15:0] = 16'h0002;
        bus0.req_valid   = 4'b0101;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus0.busy), 0);
        check("mid_rst_en", 32'(bus0.adder_enable), 0);
        check("mid_rst_a", 32'(bus0.adder_a), 0);
        check("mid_rst_b", 32'(bus0.adder_b), 0);
        check("mid_rst_sum", 32'(bus0.resp_sum), 0);
        check("mid_rst_rv", 32'(bus0.resp_valid), 0);
        check("mid_rst_ready", 32'(bus0.req_ready), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_ready", 32'(bus0.req_ready), 'h1);
        step();
        bus0.req_valid = '0;
        #1;
        check("post_rv_t1", 32'(bus0.resp_valid), 0);
        check("post_a", 32'(bus0.adder_a), 'h0001);
        step();
        check("post_rv_t2", 32'(bus0.resp_valid), 0);
        step();
        check("post_rv_t3", 32'(bus0.resp_valid), 'h1);
        check("post_sum", 32'(bus0.resp_sum), 'h0003);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
